// File: rtl/uart_param_core_if.sv
// Signal bundle between a UART user and uart_param_core: transmit request path,
// serial pins, loopback select and received-word reporting.
interface uart_param_core_if #(
    parameter int DATA_BITS = 8
);
    logic                 transmit;
    logic [DATA_BITS-1:0] TxData;
    logic                 busy;
    logic                 tx;
    logic                 rx;
    logic                 loopback;
    logic [DATA_BITS-1:0] RxData;
    logic                 valid_rx;
    logic                 parity_err;
    logic                 frame_err;

    modport slave (
        input  transmit, TxData, rx, loopback,
        output busy, tx, RxData, valid_rx, parity_err, frame_err
    );

    modport master (
        output transmit, TxData, rx, loopback,
        input  busy, tx, RxData, valid_rx, parity_err, frame_err
    );
endinterface

// File: rtl/uart_param_core.sv
// Full-duplex UART with compile-time baud divisor, data width, parity and stop bits.
// Independent TX and RX FSMs; RX can be fed from the internal tx line (loopback).
module uart_param_core #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 115_200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic        clk,
    input  logic        reset,
    uart_param_core_if.slave u
);
    localparam int CPB   = CLK_FREQ / BAUD;
    localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [CNT_W-1:0] CPB_LAST  = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CPB / 2 - 1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

    if (CPB < 4) begin : g_cpb_chk
        $error("uart_param_core: CLK_FREQ/BAUD must be at least 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_data_chk
        $error("uart_param_core: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_fmt_chk
        $error("uart_param_core: PARITY must be 0..2 and STOP_BITS 1..2");
    end

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    // Even parity is the XOR of the data bits; odd parity inverts it.
    function automatic logic par_bit(input logic [DATA_BITS-1:0] d);
        return (^d) ^ (PARITY == 1);
    endfunction

    state_t               tx_state, tx_state_n;
    logic [CNT_W-1:0]     tx_cnt, tx_cnt_n;
    logic [3:0]           tx_bit, tx_bit_n;
    logic [DATA_BITS-1:0] tx_sh, tx_sh_n;
    logic                 tx_par, tx_par_n;
    logic                 tx_q, tx_n;
    logic                 tx_bit_end;

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_bit_n   = tx_bit;
        tx_sh_n    = tx_sh;
        tx_par_n   = tx_par;
        tx_bit_end = (tx_cnt == CPB_LAST);
        if (tx_state != S_IDLE) tx_cnt_n = tx_bit_end ? '0 : tx_cnt + 1'b1;
        case (tx_state)
            S_IDLE: if (u.transmit) begin
                tx_state_n = S_START;
                tx_sh_n    = u.TxData;
                tx_par_n   = par_bit(u.TxData);
                tx_cnt_n   = '0;
                tx_bit_n   = '0;
            end
            S_START: if (tx_bit_end) tx_state_n = S_DATA;
            S_DATA: if (tx_bit_end) begin
                tx_sh_n = tx_sh >> 1;
                if (tx_bit == DATA_LAST) begin
                    tx_bit_n   = '0;
                    tx_state_n = (PARITY != 0) ? S_PAR : S_STOP;
                end else begin
                    tx_bit_n = tx_bit + 1'b1;
                end
            end
            S_PAR: if (tx_bit_end) tx_state_n = S_STOP;
            S_STOP: if (tx_bit_end) begin
                if (tx_bit == STOP_LAST) begin
                    tx_bit_n   = '0;
                    tx_state_n = S_IDLE;
                end else begin
                    tx_bit_n = tx_bit + 1'b1;
                end
            end
            default: tx_state_n = S_IDLE;
        endcase
        // Line level is decoded from the next state so tx leaves a flop.
        case (tx_state_n)
            S_START: tx_n = 1'b0;
            S_DATA:  tx_n = tx_sh_n[0];
            S_PAR:   tx_n = tx_par_n;
            default: tx_n = 1'b1;
        endcase
    end

    logic                 rx_p0, rx_p1, rx_p2;
    state_t               rx_state, rx_state_n;
    logic [CNT_W-1:0]     rx_cnt, rx_cnt_n;
    logic [3:0]           rx_bit, rx_bit_n;
    logic [DATA_BITS-1:0] rx_sh, rx_sh_n;
    logic                 rx_pbit, rx_pbit_n;
    logic                 rx_ferr, rx_ferr_n;
    logic                 rx_done;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 vld_p0, perr_q, ferr_q;
    logic                 rx_in;

    assign rx_in = u.loopback ? tx_q : u.rx;

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_bit_n   = rx_bit;
        rx_sh_n    = rx_sh;
        rx_pbit_n  = rx_pbit;
        rx_ferr_n  = rx_ferr;
        rx_done    = 1'b0;
        case (rx_state)
            S_IDLE: if (rx_p2 && !rx_p1) begin
                rx_state_n = S_START;
                rx_cnt_n   = '0;
            end
            S_START: if (rx_cnt == HALF_LAST) begin
                rx_cnt_n   = '0;
                rx_bit_n   = '0;
                rx_ferr_n  = 1'b0;
                rx_state_n = rx_p1 ? S_IDLE : S_DATA;
            end else begin
                rx_cnt_n = rx_cnt + 1'b1;
            end
            default: if (rx_cnt == CPB_LAST) begin
                rx_cnt_n = '0;
                case (rx_state)
                    S_DATA: begin
                        rx_sh_n = {rx_p1, rx_sh[DATA_BITS-1:1]};
                        if (rx_bit == DATA_LAST) begin
                            rx_bit_n   = '0;
                            rx_state_n = (PARITY != 0) ? S_PAR : S_STOP;
                        end else begin
                            rx_bit_n = rx_bit + 1'b1;
                        end
                    end
                    S_PAR: begin
                        rx_pbit_n  = rx_p1;
                        rx_state_n = S_STOP;
                    end
                    S_STOP: begin
                        rx_ferr_n = rx_ferr | ~rx_p1;
                        if (rx_bit == STOP_LAST) begin
                            rx_bit_n   = '0;
                            rx_state_n = S_IDLE;
                            rx_done    = 1'b1;
                        end else begin
                            rx_bit_n = rx_bit + 1'b1;
                        end
                    end
                    default: rx_state_n = S_IDLE;
                endcase
            end else begin
                rx_cnt_n = rx_cnt + 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state  <= S_IDLE;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_sh     <= '0;
            tx_par    <= 1'b0;
            tx_q      <= 1'b1;
            rx_p0     <= 1'b1;
            rx_p1     <= 1'b1;
            rx_p2     <= 1'b1;
            rx_state  <= S_IDLE;
            rx_cnt    <= '0;
            rx_bit    <= '0;
            rx_sh     <= '0;
            rx_pbit   <= 1'b0;
            rx_ferr   <= 1'b0;
            rx_data_q <= '0;
            vld_p0    <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_sh    <= tx_sh_n;
            tx_par   <= tx_par_n;
            tx_q     <= tx_n;
            // Synchroniser (p0, p1) then previous-sample flop (p2) for edge detect.
            rx_p0    <= rx_in;
            rx_p1    <= rx_p0;
            rx_p2    <= rx_p1;
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_sh    <= rx_sh_n;
            rx_pbit  <= rx_pbit_n;
            rx_ferr  <= rx_ferr_n;
            vld_p0   <= rx_done;
            if (rx_done) begin
                rx_data_q <= rx_sh;
                perr_q    <= (PARITY != 0) && (rx_pbit != par_bit(rx_sh));
                ferr_q    <= rx_ferr_n;
            end
        end
    end

    assign u.busy       = (tx_state != S_IDLE);
    assign u.tx         = tx_q;
    assign u.RxData     = rx_data_q;
    assign u.valid_rx   = vld_p0;
    assign u.parity_err = perr_q;
    assign u.frame_err  = ferr_q;
endmodule

// File: tb/tb_uart_param_core.sv
// Directed bench for uart_param_core: an 8N1 instance and a 7E2 instance at CPB=10,
// exercised in loopback and through bench-driven rx frames.
module tb_uart_param_core;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int tests = 0;
    int failed = 0;
    int rxa_d[$], rxa_f[$], rxb_d[$], rxb_f[$];
    int base, n;
    logic par;
    logic [7:0] seq [3];

    always #5 clk = ~clk;

    uart_param_core_if #(.DATA_BITS(8)) ifa ();
    uart_param_core_if #(.DATA_BITS(7)) ifb ();

    uart_param_core #(.CLK_FREQ(50_000_000), .BAUD(5_000_000), .DATA_BITS(8),
                      .PARITY(0), .STOP_BITS(1))
        dut_a (.clk(clk), .reset(reset), .u(ifa));
    uart_param_core #(.CLK_FREQ(50_000_000), .BAUD(5_000_000), .DATA_BITS(7),
                      .PARITY(2), .STOP_BITS(2))
        dut_b (.clk(clk), .reset(reset), .u(ifb));

    always @(negedge clk) begin
        if (ifa.valid_rx === 1'b1) begin
            rxa_d.push_back(int'(ifa.RxData));
            rxa_f.push_back(int'({ifa.frame_err, ifa.parity_err}));
        end
        if (ifb.valid_rx === 1'b1) begin
            rxb_d.push_back(int'(ifb.RxData));
            rxb_f.push_back(int'({ifb.frame_err, ifb.parity_err}));
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks that exactly one word arrived since base and that it matches.
    task automatic check_rx(input string tag, input bit sel_b, input int b,
                            input int exp_d, input int exp_f);
        int cnt, d, f;
        cnt = sel_b ? rxb_d.size() : rxa_d.size();
        d = -1;
        f = -1;
        if (cnt > 0) begin
            d = sel_b ? rxb_d[$] : rxa_d[$];
            f = sel_b ? rxb_f[$] : rxa_f[$];
        end
        check({tag, "_count"}, cnt, b + 1);
        check({tag, "_data"}, d, exp_d);
        check({tag, "_flags"}, f, exp_f);
    endtask

    // Bit-bangs an LSB-first frame on an rx pin, 10 clocks per bit, then idles high.
    task automatic drive_serial(input bit sel_b, input logic [15:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            if (sel_b) ifb.rx = bits[i];
            else       ifa.rx = bits[i];
            repeat (10) @(negedge clk);
        end
        if (sel_b) ifb.rx = 1'b1;
        else       ifa.rx = 1'b1;
    endtask

    initial begin
        ifa.transmit = 1'b0; ifa.TxData = '0; ifa.rx = 1'b1; ifa.loopback = 1'b0;
        ifb.transmit = 1'b0; ifb.TxData = '0; ifb.rx = 1'b1; ifb.loopback = 1'b0;
        seq[0] = 8'h41; seq[1] = 8'h49; seq[2] = 8'h53;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("rst_tx", ifa.tx, 1);
        check("rst_busy", ifa.busy, 0);
        check("rst_rxdata", ifa.RxData, 0);
        check("rst_valid", ifa.valid_rx, 0);
        check("rst_perr", ifa.parity_err, 0);
        check("rst_ferr", ifa.frame_err, 0);
        check("rst_b_tx", ifb.tx, 1);
        check("rst_b_busy", ifb.busy, 0);

        // Loopback 8N1, three back-to-back bytes with transmit held high
        ifa.loopback = 1'b1;
        base = rxa_d.size();
        ifa.TxData = seq[0];
        ifa.transmit = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("b2b_busy_start", ifa.busy, 1);
            check("b2b_tx_start", ifa.tx, 0);
            if (i < 2) ifa.TxData = seq[i+1];
            else       ifa.transmit = 1'b0;
            n = 0;
            while (ifa.busy === 1'b1 && n < 300) begin
                n++;
                @(negedge clk);
            end
            check("b2b_busy_len", n, 100);
        end
        repeat (20) @(negedge clk);
        check("b2b_count", rxa_d.size(), base + 3);
        for (int i = 0; i < 3; i++) begin
            check("b2b_data", (rxa_d.size() > base + i) ? rxa_d[base+i] : -1, seq[i]);
            check("b2b_flags", (rxa_f.size() > base + i) ? rxa_f[base+i] : -1, 0);
        end

        // 7E2 loopback of 0x55: parity bit 0 during cycles 81..90 of the frame
        ifb.loopback = 1'b1;
        base = rxb_d.size();
        ifb.TxData = 7'h55;
        ifb.transmit = 1'b1;
        @(negedge clk);
        ifb.transmit = 1'b0;
        n = 0;
        par = 1'bx;
        while (ifb.busy === 1'b1 && n < 300) begin
            n++;
            if (n == 85) par = ifb.tx;
            @(negedge clk);
        end
        check("par_busy_len", n, 110);
        check("par_txbit", par, 0);
        repeat (20) @(negedge clk);
        check_rx("par_loop", 1'b1, base, 'h55, 0);

        // 7E2 on the rx pin with the parity bit flipped
        ifb.loopback = 1'b0;
        base = rxb_d.size();
        drive_serial(1'b1, {5'b0, 2'b11, 1'b1, 7'h55, 1'b0}, 11);
        repeat (20) @(negedge clk);
        check_rx("par_flip", 1'b1, base, 'h55, 1);

        // 8N1 framing error: 0xA5 with a low stop bit
        ifa.loopback = 1'b0;
        base = rxa_d.size();
        drive_serial(1'b0, {6'b0, 1'b0, 8'hA5, 1'b0}, 10);
        repeat (20) @(negedge clk);
        check_rx("frame_err", 1'b0, base, 'hA5, 2);
        check("frame_err_hold", ifa.frame_err, 1);

        // Break: 300 low cycles give one errored zero word, then a clean frame
        base = rxa_d.size();
        ifa.rx = 1'b0;
        repeat (300) @(negedge clk);
        ifa.rx = 1'b1;
        repeat (30) @(negedge clk);
        check_rx("break", 1'b0, base, 0, 2);
        base = rxa_d.size();
        drive_serial(1'b0, {6'b0, 1'b1, 8'h5A, 1'b0}, 10);
        repeat (20) @(negedge clk);
        check_rx("after_break", 1'b0, base, 'h5A, 0);
        check("ferr_cleared", ifa.frame_err, 0);

        // False start: 3-cycle glitch, then 0x3C 20 cycles later
        base = rxa_d.size();
        ifa.rx = 1'b0;
        repeat (3) @(negedge clk);
        ifa.rx = 1'b1;
        repeat (20) @(negedge clk);
        check("false_start_none", rxa_d.size(), base);
        drive_serial(1'b0, {6'b0, 1'b1, 8'h3C, 1'b0}, 10);
        repeat (20) @(negedge clk);
        check_rx("false_start", 1'b0, base, 'h3C, 0);

        // Busy rejection: a second request mid-frame is dropped
        ifa.loopback = 1'b1;
        base = rxa_d.size();
        ifa.TxData = 8'h7E;
        ifa.transmit = 1'b1;
        @(negedge clk);
        ifa.transmit = 1'b0;
        repeat (30) @(negedge clk);
        ifa.TxData = 8'h11;
        ifa.transmit = 1'b1;
        @(negedge clk);
        ifa.transmit = 1'b0;
        repeat (100) @(negedge clk);
        check_rx("busy_reject", 1'b0, base, 'h7E, 0);
        check("busy_reject_idle", ifa.busy, 0);

        // Reset at cycle 40 of a 0x99 frame (data bit 2, tx low)
        base = rxa_d.size();
        ifa.TxData = 8'h99;
        ifa.transmit = 1'b1;
        @(negedge clk);
        ifa.transmit = 1'b0;
        repeat (39) @(negedge clk);
        check("rst_mid_pre_tx", ifa.tx, 0);
        reset = 1'b1;
        #1;
        check("rst_mid_tx", ifa.tx, 1);
        check("rst_mid_busy", ifa.busy, 0);
        check("rst_mid_rxdata", ifa.RxData, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (150) @(negedge clk);
        check("rst_mid_no_valid", rxa_d.size(), base);
        ifa.TxData = 8'hC3;
        ifa.transmit = 1'b1;
        @(negedge clk);
        ifa.transmit = 1'b0;
        repeat (120) @(negedge clk);
        check_rx("rst_recover", 1'b0, base, 'hC3, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/uart_param_core.md
# uart_param_core

Parametrised full-duplex UART core: independent transmitter and receiver sharing one clock and a compile-time baud divisor. Configurable data width, parity mode and stop-bit count, with parity/framing error reporting and an internal loopback mode. It is the serial endpoint behind the `uart_if` signal set (`transmit`/`TxData`/`busy`, `valid_rx`/`RxData`) and extends it with configurable framing and error flags.

## Interface
- `CLK_FREQ`, 50_000_000: clock frequency in Hz.
- `BAUD`, 115_200: bit rate. `CPB = CLK_FREQ/BAUD` (integer division) is the clocks per bit. `CPB < 4` is an elaboration `$error`.
- `DATA_BITS`, 8: data bits per frame, legal range 5..9 (elaboration `$error` otherwise).
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high; clears all state.
- `transmit` in 1: transmit request, sampled each rising edge.
- `TxData` in DATA_BITS: byte to send, captured when a request is accepted.
- `busy` out 1: transmitter occupied.
- `tx` out 1: serial output, idle high.
- `rx` in 1: serial input, asynchronous to `clk`.
- `loopback` in 1: when 1, the receiver takes the internal `tx` and ignores the `rx` pin.
- `RxData` out DATA_BITS: last received word.
- `valid_rx` out 1: one-cycle pulse when a new word is available.
- `parity_err` out 1: parity mismatch on the last word; 0 when `PARITY=0`.
- `frame_err` out 1: a stop bit sampled low on the last word.

## Operation
- **Reset values:**
  - `tx=1`, `busy=0`, `RxData=0`, `valid_rx=0`, `parity_err=0`, `frame_err=0`.
  - Both FSMs in IDLE; synchroniser flops preset to 1.
- **TX FSM:** IDLE → START → DATA → [PARITY] → STOP → IDLE.
  - IDLE with `transmit=1`: latch `TxData`, `busy=1`, go to START.
  - `transmit` while `busy=1` is ignored; no queueing.
  - Each state holds `tx` for exactly CPB cycles.
  - START drives 0. DATA sends LSB first, DATA_BITS bits.
  - PARITY bit, when enabled:
    - even mode: XOR of the data bits;
    - odd mode: the inverse of that XOR.
  - STOP drives 1 for STOP_BITS×CPB cycles. `busy` clears on the cycle after the last stop cycle.
- **RX front end:**
  - Input mux: `rx` pin or internal `tx`, selected by `loopback`.
  - Then a 2-flop synchroniser, then a previous-sample register for edge detection.
- **RX FSM:** IDLE → START → DATA → [PARITY] → STOP → IDLE.
  - IDLE: a start edge is synchronised high followed by low.
  - START: wait CPB/2 cycles, then re-sample. If high it is a false start: return to IDLE with no output.
  - DATA, PARITY, STOP: sample every CPB cycles (mid-bit). Data is shifted LSB first.
  - Every stop bit is sampled; any low stop sample sets `frame_err`.
  - After the last stop sample, in one cycle: update `RxData`, `parity_err` and `frame_err`, and pulse `valid_rx`. Words with errors are still delivered.
- **Error flags** hold until the next `valid_rx`.
- **Break (line held low):** reported as one frame with `frame_err=1`. No new frame starts until the line has been seen high, because a start needs a 1→0 edge.
- **Full duplex:** TX and RX run concurrently and independently.
- **`loopback` change mid-frame:** undefined word, but the FSM must recover to IDLE once the line has been idle for one frame.

## Timing
- Frame length: `CPB×(1+DATA_BITS+(PARITY!=0)+STOP_BITS)` cycles.
- **TX timing:**
  - `transmit` sampled high at edge T: `busy=1` and `tx=0` from T+1.
  - `busy` stays high for exactly one frame length.
  - The next request is accepted on the edge at which `busy` is first 0 (back-to-back frames, no idle gap).
- **RX latency:** `valid_rx` pulses 2 synchroniser cycles + 1 after the mid-point of the last stop bit. In loopback it lands at `T + frame_len − STOP_BITS×CPB + CPB/2 + 3` (±1).
- **Reset:**
  - Assertion takes effect immediately (asynchronous): `tx` returns high and a partial frame is abandoned.
  - Deassertion is synchronous to `clk`, via a reset synchroniser at the integration level.
- The RX mid-bit sample point tolerates ±CPB/4 accumulated drift across a frame.

## Test plan
All runs use `CLK_FREQ=50e6` and `BAUD=5e6` (CPB=10) unless noted.
- **Loopback 8N1:** send 0x41, 0x49, 0x53 back-to-back.
  - Each gives `valid_rx` with RxData equal to the sent value and both error flags 0.
  - `busy` high for 100 cycles per byte; no idle gap between frames.
- **Even parity, DATA_BITS=7, STOP_BITS=2:** loopback 0x55.
  - `tx` parity bit = 0; frame is 110 cycles; RxData = 0x55, `parity_err=0`.
  - Bench drives the `rx` pin with the parity bit flipped: `parity_err=1`, RxData still 0x55.
- **Framing error and break:**
  - `rx` driven with stop bit 0 for 0xA5: `valid_rx` with RxData=0xA5, `frame_err=1`.
  - `rx` held low for 300 cycles: exactly one `valid_rx` (RxData=0x00, `frame_err=1`); the next valid frame after the line returns high is received cleanly.
- **False start:** `rx` low pulse of 3 cycles → no `valid_rx`. A frame 0x3C sent 20 cycles later is received correctly.
- **Busy rejection and reset mid-frame:**
  - `transmit` pulsed while busy → ignored; only the first byte appears.
  - `reset` asserted at cycle 40 of a frame → `tx=1` and `busy=0` immediately, no `valid_rx`; the next byte after release round-trips correctly.
